// File: rtl/rf_op_sequencer.sv
// rf_op_sequencer: initiator-side controller for a 32x16 register file.
// It accepts one operation per handshake, reads the operands through the
// file's registered read ports, computes a 16-bit result and writes it back.
// Every operation takes the fixed path IDLE -> RD -> EX -> WB.

module rf_op_sequencer #(
    parameter bit ZERO_REG_RO = 1'b0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [2:0]  op_code,
    input  logic [4:0]  op_rd,
    input  logic [4:0]  op_rs,
    input  logic [4:0]  op_rt,
    input  logic [15:0] op_imm,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        res_ovf,
    output logic [4:0]  rf_Ra,
    output logic [4:0]  rf_Rb,
    output logic [4:0]  rf_Rw,
    output logic        rf_WrEn,
    output logic [15:0] rf_busW,
    input  logic [15:0] rf_busA,
    input  logic [15:0] rf_busB
);

    localparam logic [2:0] OP_ADD  = 3'b000;
    localparam logic [2:0] OP_SUB  = 3'b001;
    localparam logic [2:0] OP_AND  = 3'b010;
    localparam logic [2:0] OP_OR   = 3'b011;
    localparam logic [2:0] OP_ADDI = 3'b100;
    localparam logic [2:0] OP_LI   = 3'b101;
    localparam logic [2:0] OP_READ = 3'b110;
    localparam logic [2:0] OP_NOP  = 3'b111;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        RD   = 2'b01,
        EX   = 2'b10,
        WB   = 2'b11
    } state_t;

    state_t      state_r;
    logic [2:0]  code_r;
    logic [4:0]  rd_r;
    logic [15:0] imm_r;

    logic [15:0] result_s;
    logic        ovf_s;
    logic        wr_en_s;

    // Ready only in IDLE and never while reset is held, so no handshake can
    // land on a reset edge.
    assign op_ready = (state_r == IDLE) && !rst;

    // Result datapath: operands are valid from the file while in EX.
    always_comb begin
        result_s = 16'h0000;
        ovf_s    = 1'b0;
        case (code_r)
            OP_ADD: begin
                result_s = rf_busA + rf_busB;
                ovf_s    = (rf_busA[15] == rf_busB[15]) && (result_s[15] != rf_busA[15]);
            end
            OP_SUB: begin
                result_s = rf_busA - rf_busB;
                ovf_s    = (rf_busA[15] != rf_busB[15]) && (result_s[15] != rf_busA[15]);
            end
            OP_AND: begin
                result_s = rf_busA & rf_busB;
            end
            OP_OR: begin
                result_s = rf_busA | rf_busB;
            end
            OP_ADDI: begin
                result_s = rf_busA + imm_r;
                ovf_s    = (rf_busA[15] == imm_r[15]) && (result_s[15] != rf_busA[15]);
            end
            OP_LI: begin
                result_s = imm_r;
            end
            OP_READ: begin
                result_s = rf_busA;
            end
            default: begin
                result_s = 16'h0000;
                ovf_s    = 1'b0;
            end
        endcase
    end

    // Write-enable decision: READ/NOP never write, and r0 is protected when
    // the read-only zero register option is selected.
    always_comb begin
        wr_en_s = 1'b0;
        if ((code_r == OP_READ) || (code_r == OP_NOP)) begin
            wr_en_s = 1'b0;
        end else if (ZERO_REG_RO && (rd_r == 5'd0)) begin
            wr_en_s = 1'b0;
        end else begin
            wr_en_s = 1'b1;
        end
    end

    // Sequencer FSM with all outputs registered; reset drops any in-flight op.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r   <= IDLE;
            code_r    <= 3'b000;
            rd_r      <= 5'd0;
            imm_r     <= 16'h0000;
            rf_Ra     <= 5'd0;
            rf_Rb     <= 5'd0;
            rf_Rw     <= 5'd0;
            rf_WrEn   <= 1'b0;
            rf_busW   <= 16'h0000;
            res_valid <= 1'b0;
            res_data  <= 16'h0000;
            res_ovf   <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    rf_WrEn   <= 1'b0;
                    res_valid <= 1'b0;
                    if (op_valid) begin
                        code_r  <= op_code;
                        rd_r    <= op_rd;
                        imm_r   <= op_imm;
                        rf_Ra   <= op_rs;
                        rf_Rb   <= op_rt;
                        state_r <= RD;
                    end else begin
                        state_r <= IDLE;
                    end
                end
                RD: begin
                    state_r <= EX;
                end
                EX: begin
                    // NOP leaves the visible result untouched.
                    if (code_r != OP_NOP) begin
                        res_data <= result_s;
                        res_ovf  <= ovf_s;
                        rf_busW  <= result_s;
                    end else begin
                        res_data <= res_data;
                        res_ovf  <= res_ovf;
                        rf_busW  <= rf_busW;
                    end
                    rf_Rw     <= rd_r;
                    rf_WrEn   <= wr_en_s;
                    res_valid <= (code_r != OP_NOP);
                    state_r   <= WB;
                end
                WB: begin
                    rf_WrEn   <= 1'b0;
                    res_valid <= 1'b0;
                    state_r   <= IDLE;
                end
                default: begin
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rf_op_sequencer.sv
// Bench for rf_op_sequencer: two instances (ZERO_REG_RO=0 and =1) run in
// lockstep, each attached to its own behavioural 32x16 register file.
module tb_rf_op_sequencer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        op_valid = 1'b0;
    logic [2:0]  op_code = 3'b111;
    logic [4:0]  op_rd = 5'd0, op_rs = 5'd0, op_rt = 5'd0;
    logic [15:0] op_imm = 16'h0000;

    logic        op_ready0, res_valid0, res_ovf0, rf_WrEn0;
    logic [15:0] res_data0, rf_busW0, rf_busA0, rf_busB0;
    logic [4:0]  rf_Ra0, rf_Rb0, rf_Rw0;
    logic        op_ready1, res_valid1, res_ovf1, rf_WrEn1;
    logic [15:0] res_data1, rf_busW1, rf_busA1, rf_busB1;
    logic [4:0]  rf_Ra1, rf_Rb1, rf_Rw1;

    logic [15:0] file0 [32];
    logic [15:0] file1 [32];
    logic [15:0] ref0 [32];
    logic [15:0] ref1 [32];

    int checks = 0;
    int failures = 0;
    int hs_cnt = 0;

    always #5 clk = ~clk;

    rf_op_sequencer #(.ZERO_REG_RO(1'b0)) dut0 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready0),
        .op_code(op_code), .op_rd(op_rd), .op_rs(op_rs), .op_rt(op_rt), .op_imm(op_imm),
        .res_valid(res_valid0), .res_data(res_data0), .res_ovf(res_ovf0),
        .rf_Ra(rf_Ra0), .rf_Rb(rf_Rb0), .rf_Rw(rf_Rw0), .rf_WrEn(rf_WrEn0),
        .rf_busW(rf_busW0), .rf_busA(rf_busA0), .rf_busB(rf_busB0)
    );

    rf_op_sequencer #(.ZERO_REG_RO(1'b1)) dut1 (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready1),
        .op_code(op_code), .op_rd(op_rd), .op_rs(op_rs), .op_rt(op_rt), .op_imm(op_imm),
        .res_valid(res_valid1), .res_data(res_data1), .res_ovf(res_ovf1),
        .rf_Ra(rf_Ra1), .rf_Rb(rf_Rb1), .rf_Rw(rf_Rw1), .rf_WrEn(rf_WrEn1),
        .rf_busW(rf_busW1), .rf_busA(rf_busA1), .rf_busB(rf_busB1)
    );

    // Register file 0: registered read, write on WrEn, cleared by rst.
    always @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 32; i++) file0[i] <= 16'h0000;
            rf_busA0 <= 16'h0000;
            rf_busB0 <= 16'h0000;
        end else begin
            rf_busA0 <= file0[rf_Ra0];
            rf_busB0 <= file0[rf_Rb0];
            if (rf_WrEn0) file0[rf_Rw0] <= rf_busW0;
        end
    end

    // Register file 1, same behaviour.
    always @(posedge clk) begin
        if (rst) begin
            for (int j = 0; j < 32; j++) file1[j] <= 16'h0000;
            rf_busA1 <= 16'h0000;
            rf_busB1 <= 16'h0000;
        end else begin
            rf_busA1 <= file1[rf_Ra1];
            rf_busB1 <= file1[rf_Rb1];
            if (rf_WrEn1) file1[rf_Rw1] <= rf_busW1;
        end
    end

    // Handshake counter for instance 0.
    always @(posedge clk) begin
        if (op_valid && op_ready0) hs_cnt <= hs_cnt + 1;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Reference arithmetic on signed integers; overflow = result out of 16-bit range.
    function automatic void ref_calc(input logic [2:0] c, input logic [15:0] a, input logic [15:0] b,
                                     input logic [15:0] imm, output logic [15:0] r, output logic o);
        int sa, sb, si, t;
        sa = int'($signed(a));
        sb = int'($signed(b));
        si = int'($signed(imm));
        t = 0;
        r = 16'h0000;
        o = 1'b0;
        case (c)
            3'd0: begin t = sa + sb; r = t[15:0]; o = (t > 32767) || (t < -32768); end
            3'd1: begin t = sa - sb; r = t[15:0]; o = (t > 32767) || (t < -32768); end
            3'd2: r = a & b;
            3'd3: r = a | b;
            3'd4: begin t = sa + si; r = t[15:0]; o = (t > 32767) || (t < -32768); end
            3'd5: r = imm;
            3'd6: r = a;
            default: r = 16'h0000;
        endcase
    endfunction

    task automatic check_cycle(input int k, input string tag, input logic rdy, input logic rv,
                               input logic we, input logic [4:0] rw, input logic [15:0] bw,
                               input logic [15:0] rdat, input logic rovf, input logic exp_rv,
                               input logic exp_we, input logic [4:0] exp_rw,
                               input logic [15:0] exp_d, input logic exp_o);
        chk({tag, "_op_ready"}, {31'd0, rdy}, {31'd0, (k == 4)});
        chk({tag, "_res_valid"}, {31'd0, rv}, {31'd0, (k == 3) && exp_rv});
        chk({tag, "_rf_WrEn"}, {31'd0, we}, {31'd0, (k == 3) && exp_we});
        if ((k == 3) && exp_rv) begin
            chk({tag, "_res_data"}, {16'd0, rdat}, {16'd0, exp_d});
            chk({tag, "_res_ovf"}, {31'd0, rovf}, {31'd0, exp_o});
        end
        if ((k == 3) && exp_we) begin
            chk({tag, "_rf_Rw"}, {27'd0, rw}, {27'd0, exp_rw});
            chk({tag, "_rf_busW"}, {16'd0, bw}, {16'd0, exp_d});
        end
        if ((k == 4) && exp_rv) chk({tag, "_res_hold"}, {16'd0, rdat}, {16'd0, exp_d});
    endtask

    // One full operation, entered at a negedge; returns at the negedge after
    // the fourth edge, with op_valid dropped (a following call may raise it
    // again in zero time, so op_valid can stay high across back-to-back ops).
    task automatic do_op(input logic [2:0] c, input logic [4:0] rd, input logic [4:0] rs,
                         input logic [4:0] rt, input logic [15:0] imm,
                         output logic [15:0] got0, output logic [15:0] got1, output logic gov0);
        logic [15:0] e0, e1;
        logic        o0, o1, w0, w1, rv;
        int waited;
        waited = 0;
        got0 = 16'h0000; got1 = 16'h0000; gov0 = 1'b0;
        while (!(op_ready0 && op_ready1) && (waited < 20)) begin
            @(negedge clk);
            waited++;
        end
        chk("ready_timeout", {31'd0, (waited >= 20)}, 32'd0);
        ref_calc(c, ref0[rs], ref0[rt], imm, e0, o0);
        ref_calc(c, ref1[rs], ref1[rt], imm, e1, o1);
        rv = (c != 3'd7);
        w0 = (c != 3'd6) && (c != 3'd7);
        w1 = w0 && (rd != 5'd0);
        op_valid = 1'b1;
        op_code = c; op_rd = rd; op_rs = rs; op_rt = rt; op_imm = imm;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            check_cycle(k, "d0", op_ready0, res_valid0, rf_WrEn0, rf_Rw0, rf_busW0, res_data0,
                        res_ovf0, rv, w0, rd, e0, o0);
            check_cycle(k, "d1", op_ready1, res_valid1, rf_WrEn1, rf_Rw1, rf_busW1, res_data1,
                        res_ovf1, rv, w1, rd, e1, o1);
            if (k == 3) begin
                got0 = res_data0; got1 = res_data1; gov0 = res_ovf0;
            end
            // Garbage fields while busy must be ignored.
            op_code = 3'($urandom_range(0, 7));
            op_rd = 5'($urandom_range(0, 31));
            op_rs = 5'($urandom_range(0, 31));
            op_rt = 5'($urandom_range(0, 31));
            op_imm = 16'($urandom_range(0, 65535));
            if (k == 4) op_valid = 1'b0;
        end
        if (w0) ref0[rd] = e0;
        if (w1) ref1[rd] = e1;
    endtask

    typedef struct {
        logic [2:0]  code;
        logic [4:0]  rd, rs, rt;
        logic [15:0] imm;
        logic [15:0] exp0;
        logic [15:0] exp1;
        logic        ovf;
    } vec_t;

    vec_t vecs [10];

    initial begin
        logic [15:0] g0, g1;
        logic        gv;
        int hs_before;

        vecs[0] = '{3'd5, 5'd1, 5'd0, 5'd0, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b0};
        vecs[1] = '{3'd5, 5'd2, 5'd0, 5'd0, 16'h0001, 16'h0001, 16'h0001, 1'b0};
        vecs[2] = '{3'd0, 5'd3, 5'd1, 5'd2, 16'h0000, 16'h8000, 16'h8000, 1'b1};
        vecs[3] = '{3'd6, 5'd9, 5'd3, 5'd0, 16'h0000, 16'h8000, 16'h8000, 1'b0};
        vecs[4] = '{3'd1, 5'd4, 5'd2, 5'd1, 16'h0000, 16'h8002, 16'h8002, 1'b0};
        vecs[5] = '{3'd4, 5'd5, 5'd4, 5'd0, 16'hFFFE, 16'h8000, 16'h8000, 1'b0};
        vecs[6] = '{3'd2, 5'd6, 5'd1, 5'd3, 16'h0000, 16'h0000, 16'h0000, 1'b0};
        vecs[7] = '{3'd3, 5'd7, 5'd1, 5'd3, 16'h0000, 16'hFFFF, 16'hFFFF, 1'b0};
        vecs[8] = '{3'd5, 5'd0, 5'd0, 5'd0, 16'h1234, 16'h1234, 16'h1234, 1'b0};
        vecs[9] = '{3'd6, 5'd11, 5'd0, 5'd0, 16'h0000, 16'h1234, 16'h0000, 1'b0};

        for (int i = 0; i < 32; i++) begin
            ref0[i] = 16'h0000;
            ref1[i] = 16'h0000;
        end

        // Reset values.
        repeat (2) @(negedge clk);
        chk("rst_op_ready", {31'd0, op_ready0}, 32'd0);
        chk("rst_res_valid", {31'd0, res_valid0}, 32'd0);
        chk("rst_rf_WrEn", {31'd0, rf_WrEn0}, 32'd0);
        chk("rst_res_data", {16'd0, res_data0}, 32'd0);
        chk("rst_res_ovf", {31'd0, res_ovf0}, 32'd0);
        chk("rst_rf_Ra", {27'd0, rf_Ra0}, 32'd0);
        chk("rst_rf_busW", {16'd0, rf_busW0}, 32'd0);
        rst = 1'b0;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, op_ready0}, 32'd1);

        // Directed vectors with constant expectations.
        for (int v = 0; v < 10; v++) begin
            do_op(vecs[v].code, vecs[v].rd, vecs[v].rs, vecs[v].rt, vecs[v].imm, g0, g1, gv);
            chk($sformatf("vec%0d_d0", v), {16'd0, g0}, {16'd0, vecs[v].exp0});
            chk($sformatf("vec%0d_d1", v), {16'd0, g1}, {16'd0, vecs[v].exp1});
            chk($sformatf("vec%0d_ovf", v), {31'd0, gv}, {31'd0, vecs[v].ovf});
        end

        // op_valid held high across three queued ops (incl. a NOP).
        hs_before = hs_cnt;
        do_op(3'd5, 5'd9, 5'd0, 5'd0, 16'h00AA, g0, g1, gv);
        do_op(3'd7, 5'd12, 5'd9, 5'd9, 16'h5555, g0, g1, gv);
        do_op(3'd0, 5'd10, 5'd9, 5'd9, 16'h0000, g0, g1, gv);
        chk("queued_handshakes", hs_cnt - hs_before, 32'd3);
        chk("queued_add", {16'd0, g0}, 32'h0000_0154);

        // Reset while ADD r8 is in EX: no write, no result pulse.
        op_valid = 1'b1;
        op_code = 3'd0; op_rd = 5'd8; op_rs = 5'd9; op_rt = 5'd9; op_imm = 16'h0000;
        @(negedge clk);
        op_valid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_WrEn0", {31'd0, rf_WrEn0}, 32'd0);
        chk("midrst_valid0", {31'd0, res_valid0}, 32'd0);
        chk("midrst_ready0", {31'd0, op_ready0}, 32'd0);
        chk("midrst_WrEn1", {31'd0, rf_WrEn1}, 32'd0);
        rst = 1'b0;
        for (int i = 0; i < 32; i++) begin
            ref0[i] = 16'h0000;
            ref1[i] = 16'h0000;
        end
        @(negedge clk);
        chk("afterrst_ready0", {31'd0, op_ready0}, 32'd1);
        chk("afterrst_WrEn0", {31'd0, rf_WrEn0}, 32'd0);
        chk("afterrst_valid0", {31'd0, res_valid0}, 32'd0);
        do_op(3'd6, 5'd13, 5'd8, 5'd0, 16'h0000, g0, g1, gv);
        chk("read_r8_after_rst", {16'd0, g0}, 32'd0);

        // Randomized ops against the reference model.
        for (int n = 0; n < 60; n++) begin
            do_op(3'($urandom_range(0, 7)), 5'($urandom_range(0, 31)),
                  5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)),
                  16'($urandom_range(0, 65535)), g0, g1, gv);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
